add_sub_pipe: RTL and testbench

- Parametrised, pipelined two's-complement adder/subtractor with carry/borrow-in, signed overflow detection and optional saturation.
- Successor to the fixed-width 20-bit ripple adder used for score and position arithmetic in the arcade datapath.
- Carry chain is split into SEG-bit slices, one register stage per slice, to close timing at the board clock. Uses valid/ready handshake on both sides.

---
 rtl/add_sub_pipe.sv | 121 ++++++++++++
 tb/tb_add_sub_pipe.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/add_sub_pipe.sv
// Pipelined two's-complement adder/subtractor: the carry chain is cut into SEG-bit slices with
// one register stage per slice, plus signed overflow detection and optional saturation.
module add_sub_pipe #(
    parameter int unsigned WIDTH    = 20,
    parameter int unsigned SEG      = 5,
    parameter bit          SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             ci,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int unsigned N = WIDTH / SEG;

    // Entry k holds the operands, the partial sum with slices 0..k filled, and the slice-k carry.
    logic [N-1:0]     vld_q, vld_d;
    logic [N-1:0]     cry_q, cry_d;
    logic [WIDTH-1:0] opa_q [N];
    logic [WIDTH-1:0] opa_d [N];
    logic [WIDTH-1:0] opb_q [N];
    logic [WIDTH-1:0] opb_d [N];
    logic [WIDTH-1:0] sum_q [N];
    logic [WIDTH-1:0] sum_d [N];

    logic             advance;
    logic             src_v;
    logic             src_c;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] src_sum;
    logic [SEG:0]     slice;

    logic [WIDTH-1:0] raw_sum;
    logic             sign_a;
    logic             sign_b;

    assign advance  = out_ready || !out_valid;
    assign in_ready = advance;

    always_comb begin
        vld_d   = vld_q;
        cry_d   = cry_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sum_d   = sum_q;
        src_v   = 1'b0;
        src_c   = 1'b0;
        src_a   = '0;
        src_b   = '0;
        src_sum = '0;
        slice   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (k == 0) begin
                // Subtract is add of the inverted operand with an inverted borrow as carry-in.
                src_v   = in_valid;
                src_a   = A;
                src_b   = op ? ~B : B;
                src_c   = op ? ~ci : ci;
                src_sum = '0;
            end else begin
                src_v   = vld_q[k-1];
                src_a   = opa_q[k-1];
                src_b   = opb_q[k-1];
                src_c   = cry_q[k-1];
                src_sum = sum_q[k-1];
            end
            slice = {1'b0, src_a[k*SEG +: SEG]} + {1'b0, src_b[k*SEG +: SEG]}
                  + {{SEG{1'b0}}, src_c};
            vld_d[k]                  = src_v;
            opa_d[k]                  = src_a;
            opb_d[k]                  = src_b;
            sum_d[k]                  = src_sum;
            sum_d[k][k*SEG +: SEG]    = slice[SEG-1:0];
            cry_d[k]                  = slice[SEG];
        end
    end

    // Every stage moves together; bubbles are kept so ordering and latency stay fixed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            cry_q <= '0;
            for (int unsigned k = 0; k < N; k++) begin
                opa_q[k] <= '0;
                opb_q[k] <= '0;
                sum_q[k] <= '0;
            end
        end else if (advance) begin
            vld_q <= vld_d;
            cry_q <= cry_d;
            opa_q <= opa_d;
            opb_q <= opb_d;
            sum_q <= sum_d;
        end
    end

    assign raw_sum   = sum_q[N-1];
    assign sign_a    = opa_q[N-1][WIDTH-1];
    assign sign_b    = opb_q[N-1][WIDTH-1];
    assign out_valid = vld_q[N-1];
    assign carry_out = cry_q[N-1];
    assign overflow  = (sign_a == sign_b) && (raw_sum[WIDTH-1] != sign_a);

    always_comb begin
        result = raw_sum;
        if (SATURATE && overflow) begin
            result = sign_a ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

endmodule

// File: tb/tb_add_sub_pipe.sv
// Bench for add_sub_pipe: four instances (N=4 saturating, N=4 wrapping, N=1, N=10) share stimulus;
// each is scored against an arithmetic reference model through its own expected-result queue.
module tb_add_sub_pipe;

    localparam int W  = 20;
    localparam int ND = 4;
    localparam int LAT [ND] = '{4, 4, 1, 10};
    localparam bit [ND-1:0] SAT_MASK = 4'b1101;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic          ci = 1'b0;
    logic          op = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;

    logic [ND-1:0] rdy_w, ov_w, ovf_w, co_w;
    logic [W-1:0]  res_w [ND];

    int            n_vec = 0;
    int            n_err = 0;
    int            n_out [ND] = '{0, 0, 0, 0};
    logic [21:0]   exp_q [ND][$];

    always #5 clk = ~clk;

    add_sub_pipe #(.WIDTH(W), .SEG(5), .SATURATE(1'b1)) u_sat4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_w[0]), .A(a), .B(b),
        .ci(ci), .op(op), .out_valid(ov_w[0]), .out_ready(out_ready), .result(res_w[0]),
        .carry_out(co_w[0]), .overflow(ovf_w[0])
    );
    add_sub_pipe #(.WIDTH(W), .SEG(5), .SATURATE(1'b0)) u_wrap4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_w[1]), .A(a), .B(b),
        .ci(ci), .op(op), .out_valid(ov_w[1]), .out_ready(out_ready), .result(res_w[1]),
        .carry_out(co_w[1]), .overflow(ovf_w[1])
    );
    add_sub_pipe #(.WIDTH(W), .SEG(20), .SATURATE(1'b1)) u_sat1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_w[2]), .A(a), .B(b),
        .ci(ci), .op(op), .out_valid(ov_w[2]), .out_ready(out_ready), .result(res_w[2]),
        .carry_out(co_w[2]), .overflow(ovf_w[2])
    );
    add_sub_pipe #(.WIDTH(W), .SEG(2), .SATURATE(1'b1)) u_sat10 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_w[3]), .A(a), .B(b),
        .ci(ci), .op(op), .out_valid(ov_w[3]), .out_ready(out_ready), .result(res_w[3]),
        .carry_out(co_w[3]), .overflow(ovf_w[3])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: exact integer arithmetic, then range check / clamp / wrap. Returns {co, ovf, res}.
    function automatic logic [21:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                          input logic mci, input logic mop, input bit msat);
        longint sa, sb, ua, ub, cl, exact;
        logic [63:0] ex_u;
        logic co, ovf;
        logic [W-1:0] res;
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        ua = longint'(ma);
        ub = longint'(mb);
        cl = longint'(mci);
        exact = mop ? (sa - sb - cl) : (sa + sb + cl);
        co  = mop ? (ua >= ub + cl) : ((ua + ub + cl) >= 1048576);
        ovf = (exact > 524287) || (exact < -524288);
        ex_u = exact;
        res = ex_u[W-1:0];
        if (msat && ovf) res = (exact < 0) ? 20'h80000 : 20'h7FFFF;
        return {co, ovf, res};
    endfunction

    // Transfers are decided on the posedge; inputs are stable from posedge+1, so sample at negedge.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int d = 0; d < ND; d++) exp_q[d].delete();
        end else begin
            for (int d = 0; d < ND; d++) begin
                if (ov_w[d] && out_ready) begin
                    if (exp_q[d].size() == 0) begin
                        check($sformatf("dut%0d_spurious_out", d), 32'(ov_w[d]), 32'd0);
                    end else begin
                        check($sformatf("dut%0d_result", d),
                              32'({co_w[d], ovf_w[d], res_w[d]}), 32'(exp_q[d].pop_front()));
                        n_out[d]++;
                    end
                end
                if (in_valid && rdy_w[d]) exp_q[d].push_back(model(a, b, ci, op, SAT_MASK[d]));
            end
        end
    end

    task automatic lat_probe(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb2,
                             input logic tci, input logic top, input logic [W-1:0] exp0);
        a = ta; b = tb2; ci = tci; op = top; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, 32'(rdy_w[0]), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int e = 1; e <= 11; e++) begin
            for (int d = 0; d < ND; d++)
                check($sformatf("%s_valid_dut%0d_edge%0d", tag, d, e), 32'(ov_w[d]),
                      32'(e == LAT[d]));
            if (e == 4) check({tag, "_result"}, 32'(res_w[0]), 32'(exp0));
            @(posedge clk); #1;
        end
    endtask

    task automatic xact(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic tci,
                        input logic top, output logic v0, output logic [21:0] o0,
                        output logic [21:0] o1);
        a = ta; b = tb2; ci = tci; op = top; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        v0 = ov_w[0];
        o0 = {co_w[0], ovf_w[0], res_w[0]};
        o1 = {co_w[1], ovf_w[1], res_w[1]};
        repeat (8) @(posedge clk);
        #1;
    endtask

    initial begin : main
        logic        v0;
        logic [21:0] o0, o1;
        int          k, stall, base, cnt;
        bit          seen, acc;
        int          base_out [ND];

        #23 rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_out_valid", 32'(ov_w), 32'd0);
        check("reset_in_ready", 32'(rdy_w), 32'hF);
        check("reset_result", 32'(res_w[0]), 32'd0);
        check("reset_flags", 32'({co_w, ovf_w}), 32'd0);

        // Latency and one-cycle-high valid on each depth.
        lat_probe("t1", 20'd100, 20'd23, 1'b0, 1'b0, 20'd123);

        xact(20'd5, 20'd9, 1'b0, 1'b1, v0, o0, o1);
        check("t2_sub_valid", 32'(v0), 32'd1);
        check("t2_sub", 32'(o0), 32'({1'b0, 1'b0, 20'hFFFFC}));
        xact(20'd0, 20'd0, 1'b1, 1'b1, v0, o0, o1);
        check("t2_zero_borrow_sat", 32'(o0), 32'({1'b0, 1'b0, 20'hFFFFF}));
        check("t2_zero_borrow_wrap", 32'(o1), 32'({1'b0, 1'b0, 20'hFFFFF}));

        xact(20'h7FFFF, 20'd1, 1'b0, 1'b0, v0, o0, o1);
        check("t3_posovf_sat", 32'(o0), 32'({1'b0, 1'b1, 20'h7FFFF}));
        check("t3_posovf_wrap", 32'(o1), 32'({1'b0, 1'b1, 20'h80000}));
        xact(20'h80000, 20'd1, 1'b0, 1'b1, v0, o0, o1);
        check("t3_negovf_sat", 32'(o0), 32'({1'b1, 1'b1, 20'h80000}));
        check("t3_negovf_wrap", 32'(o1), 32'({1'b1, 1'b1, 20'h7FFFF}));

        // Back-to-back stream with a 3-cycle downstream stall after the first result.
        k = 0; stall = 0; seen = 1'b0; base = n_out[0];
        for (int cyc = 0; cyc < 30; cyc++) begin
            in_valid = (k < 8); a = W'(k); b = 20'd1000; ci = 1'b0; op = 1'b0;
            if (ov_w[0] && !seen) begin seen = 1'b1; stall = 3; end
            out_ready = (stall == 0);
            #1;
            if (stall > 0) begin
                check("t4_stall_in_ready", 32'(rdy_w[0]), 32'd0);
                check("t4_stall_valid", 32'(ov_w[0]), 32'd1);
                check("t4_stall_result", 32'(res_w[0]), 32'd1000);
                stall--;
            end
            acc = in_valid && rdy_w[0];
            @(posedge clk); #1;
            if (acc) k++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("t4_first_seen", 32'(seen), 32'd1);
        check("t4_accepts", 32'(k), 32'd8);
        check("t4_outputs", 32'(n_out[0] - base), 32'd8);
        repeat (12) @(posedge clk);
        #1;

        // Random handshake soak.
        for (int d = 0; d < ND; d++) base_out[d] = n_out[d];
        for (int cyc = 0; cyc < 2000; cyc++) begin
            in_valid = 1'($urandom); out_ready = 1'($urandom);
            a = ($urandom_range(0, 7) == 0) ? 20'h80000 : W'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 20'h7FFFF : W'($urandom);
            ci = 1'($urandom); op = 1'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) begin
            check($sformatf("t5_drained_dut%0d", d), 32'(exp_q[d].size()), 32'd0);
            check($sformatf("t5_progress_dut%0d", d), 32'(n_out[d] - base_out[d] > 300), 32'd1);
        end

        // Reset with transactions in flight.
        for (int j = 0; j < 4; j++) begin
            in_valid = 1'b1; a = W'(j + 50); b = 20'd7; ci = 1'b0; op = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("t6_pre_valid", 32'(ov_w[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_valid", 32'(ov_w), 32'd0);
        check("t6_async_result", 32'(res_w[0]), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        cnt = 0;
        for (int cyc = 0; cyc < 15; cyc++) begin
            cnt += int'(ov_w != 0);
            @(posedge clk); #1;
        end
        check("t6_no_ghosts", 32'(cnt), 32'd0);
        lat_probe("t6", 20'd300, 20'd45, 1'b1, 1'b1, 20'd254);
        for (int d = 0; d < ND; d++)
            check($sformatf("t6_drained_dut%0d", d), 32'(exp_q[d].size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
